// File: rtl/rv32_lsu_dmem.sv
// RV32 load/store unit with word-organised data memory, req/rsp handshake and LATENCY wait states.
// Optional misalignment faults are enabled by defining RV32_LSU_MISALIGN_TRAP_EN.
module rv32_lsu_dmem #(
  parameter int XLEN     = 32,
  parameter int MEM_SIZE = 2048,
  parameter int LATENCY  = 1
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_we_i,
  input  logic [2:0]      req_funct3_i,
  input  logic [XLEN-1:0] req_addr_i,
  input  logic [XLEN-1:0] req_wdata_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [XLEN-1:0] rsp_rdata_o,
  output logic            rsp_err_o,
  input  logic [XLEN-1:0] dbg_addr_i,
  output logic [XLEN-1:0] dbg_data_o
);

  localparam int AW = $clog2(MEM_SIZE);
  localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  // Handshake: a request transfers on a rising edge with req_valid_i && req_ready_o;
  // a response transfers on a rising edge with rsp_valid_o && rsp_ready_i.
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            err_q, err_d;

  logic [XLEN-1:0] mem [MEM_SIZE];

  logic            commit;
  logic            mem_we;
  logic            acc_we;
  logic [2:0]      acc_f3;
  logic [XLEN-1:0] acc_addr;
  logic [XLEN-1:0] acc_wdata;
  logic [AW-1:0]   acc_idx;
  logic [1:0]      acc_lane;
  logic [XLEN-1:0] acc_word;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic [XLEN-1:0] load_val;
  logic [XLEN-1:0] store_data;
  logic [3:0]      store_be;
  logic            acc_err;
  logic            unused_dbg_hi;

  assign unused_dbg_hi = ^dbg_addr_i[XLEN-1:AW];

  // With LATENCY=0 the access happens on the accept edge, so it uses the live request.
  assign commit = rstn_i && (((state_q == IDLE) && req_valid_i && (LATENCY == 0)) ||
                             ((state_q == WAIT) && (cnt_q == 4'd0)));

  always_comb begin
    acc_we    = (state_q == IDLE) ? req_we_i     : we_q;
    acc_f3    = (state_q == IDLE) ? req_funct3_i : funct3_q;
    acc_addr  = (state_q == IDLE) ? req_addr_i   : addr_q;
    acc_wdata = (state_q == IDLE) ? req_wdata_i  : wdata_q;
    acc_idx   = acc_addr[AW+1:2];
    acc_lane  = acc_addr[1:0];
    acc_word  = mem[acc_idx];
    byte_sel  = acc_word[8*acc_lane +: 8];
    half_sel  = acc_lane[1] ? acc_word[31:16] : acc_word[15:0];

    acc_err = ((acc_addr >> (AW + 2)) != '0);
    if (acc_we) acc_err = acc_err || (acc_f3 >= 3'd3);
    else        acc_err = acc_err || (acc_f3 == 3'd3) || (acc_f3 == 3'd6) || (acc_f3 == 3'd7);
`ifdef RV32_LSU_MISALIGN_TRAP_EN
    if ((acc_f3[1:0] == 2'd1) && acc_lane[0])      acc_err = 1'b1;
    if ((acc_f3[1:0] == 2'd2) && (acc_lane != 2'd0)) acc_err = 1'b1;
`endif

    load_val = '0;
    case (acc_f3)
      3'd0:    load_val = {{24{byte_sel[7]}}, byte_sel};
      3'd1:    load_val = {{16{half_sel[15]}}, half_sel};
      3'd2:    load_val = acc_word;
      3'd4:    load_val = {24'd0, byte_sel};
      3'd5:    load_val = {16'd0, half_sel};
      default: load_val = '0;
    endcase

    store_be   = 4'b0000;
    store_data = acc_wdata;
    case (acc_f3[1:0])
      2'd0: begin
        store_be   = 4'b0001 << acc_lane;
        store_data = {4{acc_wdata[7:0]}};
      end
      2'd1: begin
        store_be   = acc_lane[1] ? 4'b1100 : 4'b0011;
        store_data = {2{acc_wdata[15:0]}};
      end
      2'd2:    store_be = 4'b1111;
      default: store_be = 4'b0000;
    endcase

    mem_we = commit && acc_we && !acc_err;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    funct3_d    = funct3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          we_d     = req_we_i;
          funct3_d = req_funct3_i;
          addr_d   = req_addr_i;
          wdata_d  = req_wdata_i;
          if (LATENCY == 0) begin
            state_d = RESP;
          end else begin
            cnt_d   = CNT_INIT;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (commit) begin
      err_d   = acc_err;
      rdata_d = (acc_err || acc_we) ? '0 : load_val;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      we_q     <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Data store is deliberately not reset; only enabled byte lanes are written.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (store_be[i]) mem[acc_idx][8*i +: 8] <= store_data[8*i +: 8];
      end
    end
  end

  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;
  assign dbg_data_o  = mem[dbg_addr_i[AW-1:0]];

endmodule

// File: doc/rv32_lsu_dmem.md
# rv32_lsu_dmem

Parametrised load/store unit plus data memory for the RV32 core family. It is the successor to the single-cycle core's inline data array. Accesses use a request/response handshake with configurable wait states. Byte and halfword accesses use byte lanes with correct sign/zero extension, and misaligned, out-of-range and illegal-funct3 accesses are reported as errors. It sits between the core's execute stage and the word-addressed data store, and gives testbench/display logic a combinational debug read port.

## Interface
- XLEN, 32, data/address width; only 32 supported
- MEM_SIZE, 2048, memory depth in 32-bit words; power of two, ≥4
- LATENCY, 1, wait states between accept and response; range 0..15
- clk_i  input  1  clock, rising edge
- rstn_i  input  1  reset, asynchronous, active-low
- req_valid_i  input  1  request valid
- req_ready_o  output  1  unit can accept a request
- req_we_i  input  1  1 = store, 0 = load
- req_funct3_i  input  3  RV32I load/store funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
- req_addr_i  input  XLEN  byte address (rs1 + imm, computed by core)
- req_wdata_i  input  XLEN  store data (rs2), lane-aligned by this unit
- rsp_valid_o  output  1  response valid
- rsp_ready_i  input  1  core accepts response
- rsp_rdata_o  output  XLEN  extended load data; 0 for stores and errors
- rsp_err_o  output  1  access faulted; no memory side effect
- dbg_addr_i  input  XLEN  debug word index
- dbg_data_o  output  XLEN  memory word at dbg_addr_i[$clog2(MEM_SIZE)-1:0], combinational

## Operation
- FSM states: IDLE, WAIT, RESP. Reset state IDLE.
- IDLE: req_ready_o=1. On req_valid_i, register we/funct3/addr/wdata. If LATENCY=0 go to RESP, otherwise load wait counter with LATENCY-1 and go to WAIT.
- WAIT: req_ready_o=0. Counter decrements each cycle. At 0 go to RESP.
- Memory access happens on the edge that enters RESP: store lanes are written, load word is captured.
- RESP: rsp_valid_o=1 and outputs held stable until rsp_ready_i. Handshake edge returns to IDLE. No request accepted in the same cycle, so the maximum rate is one access per LATENCY+2 cycles.
- Word index = addr[$clog2(MEM_SIZE)+1:2]. Byte lane = addr[1:0].
- Stores: SB writes byte lane addr[1:0] with wdata[7:0]. SH writes half addr[1] with wdata[15:0]. SW writes the full word. Untouched lanes are preserved.
- Loads: LB/LBU select byte addr[1:0], sign-/zero-extended to 32. LH/LHU select half addr[1], sign-/zero-extended. LW returns the full word.
- Error conditions (rsp_err_o=1, rsp_rdata_o=0, memory unchanged):
  - addr ≥ MEM_SIZE*4
  - load funct3 ∈ {3,6,7}
  - store funct3 ≥ 3
  - misalignment, when enabled (see Configuration)
- Memory array is not reset. Contents are undefined until written.

## Timing
- Reset values (asynchronous): state IDLE, req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, wait counter 0. Memory is untouched by reset.
- Accept-to-rsp_valid latency: LATENCY+1 cycles.
- Reset asserted mid-access (WAIT or RESP): the transaction is dropped, no response is issued, and the FSM returns to IDLE.
  - A store that has not yet reached RESP is not committed.
  - A store already committed stays written.
- rsp_ready_i held high ahead of time: the response completes in its first RESP cycle.
- req_valid_i outside IDLE is ignored. The requester must hold it until the handshake.
- dbg_data_o shows a store's result from the cycle after the commit edge.

## Configuration
- RV32_LSU_MISALIGN_TRAP_EN defined:
  - LH/LHU/SH with addr[0]≠0 fault with rsp_err_o=1.
  - LW/SW with addr[1:0]≠0 fault with rsp_err_o=1.
- Undefined:
  - Misalignment is never an error.
  - Halfword accesses use half addr[1] and ignore addr[0].
  - Word accesses ignore addr[1:0].
- Range and funct3 errors are always active.

## Test plan
- LATENCY=1: SW 0xDEADBEEF at addr 0x10, then LW 0x10 → rsp_valid_o 2 cycles after each accept, rdata 0xDEADBEEF, err 0, dbg_addr_i=4 shows 0xDEADBEEF.
- Word 0x10 = 0xDEADBEEF; SB 0x5A at 0x12 → word 0xDE5ABEEF. Then:
  - LB 0x13 → 0xFFFFFFDE
  - LBU 0x13 → 0x000000DE
  - LH 0x12 → 0xFFFFDE5A
  - LHU 0x10 → 0x0000BEEF
- Hold rsp_ready_i=0 for 5 cycles in RESP → rsp_valid_o and rdata stable, req_ready_o=0, a new request is not accepted; release → back to IDLE next cycle.
- Macro defined: LW at 0x11 → err 1, rdata 0. SW at 0x12 → err 1, word unchanged. Macro undefined: LW 0x11 returns the word at 0x10.
- SW at MEM_SIZE*4 → err 1, word 0 unchanged. LB with funct3=3 → err 1.
- LATENCY=4: SW accepted, rstn_i pulsed low during WAIT → no rsp_valid_o, req_ready_o=1 after release, target word unchanged.
